shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
Multi-cycle shift controller for the 16-bit ALU datapath. It accepts an operand, a shift amount (0-15), a direction and an arithmetic/logical mode. It then sequences the existing single-position combinational shifter, one position per clock, until the requested amount is reached. The result is returned over a valid/ready handshake, together with a sticky flag that reports whether any 1 bit was shifted out.

Parameters:
WIDTH, 16, operand/result width; only 16 is supported because the 1-bit shifter is fixed at 16 bits.
AMT_W, 4, shift-amount width; equals clog2(WIDTH).

Ports:
clk  input  1  single system clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
start_valid  input  1  request present.
start_ready  output  1  sequencer can accept a request; high only in IDLE.
operand  input  WIDTH  value to shift; sampled on accept.
amount  input  AMT_W  number of positions; sampled on accept.
dir  input  1  0 = left, 1 = right; sampled on accept.
arith  input  1  1 = arithmetic right shift (sign fill); ignored for left shifts; sampled on accept.
abort  input  1  cancel an in-progress shift.
result  output  WIDTH  shifted value; stable while result_valid is high.
result_valid  output  1  result available.
result_ready  input  1  consumer accepts the result.
bits_lost  output  1  sticky: a 1 bit left the word during this operation.
busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (async assert, sync release): state = IDLE; result = 0x0000; result_valid = 0; bits_lost = 0; busy = 0; internal count = 0. start_ready = 1 after reset.
- States: IDLE, SHIFT, DONE. Encoding is 2-bit, defined in the package.
- IDLE:
  - On start_valid & start_ready, latch operand into the working register; latch dir and arith; count <= amount; clear bits_lost.
  - amount == 0 -> go to DONE. result = operand, valid on the next cycle (latency 1).
  - amount != 0 -> go to SHIFT.
- SHIFT, per cycle:
  - Working register <= shifter output (leftShift or rightShift).
  - Right + arith: bit 15 is forced to the pre-shift bit 15.
  - bits_lost |= shifted-out bit: bit 15 for left, bit 0 for right.
  - count decrements; when count == 1 on this edge, go to DONE.
  - Total latency from accept to result_valid = amount + 1 cycles.
- DONE:
  - result_valid = 1; result and bits_lost are held.
  - On result_ready, go to IDLE. result_valid drops the next cycle; result keeps its last value.
  - start_valid is not accepted in DONE, so there is no same-cycle turnaround. The next accept is earliest in the cycle after the return to IDLE.
- abort:
  - In SHIFT -> go to IDLE next edge. No result_valid is produced; result is unchanged from its previous value; bits_lost is cleared.
  - In IDLE or DONE, abort is ignored.
  - abort has priority over the SHIFT -> DONE transition in the same cycle.
- Left arith is identical to logical left.
- Right logical fills with 0; right arith replicates the sign bit.
- Inputs operand/amount/dir/arith are don't-care outside the accept cycle.
- Asserting rst_n low in any state returns every output to its reset value immediately, without waiting for a clock edge.
- Throughput: one operation per amount + 2 cycles minimum, when result_ready is held high.

Decomposition:
- Package shift_pkg holds:
  - state encoding constants ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2;
  - DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1;
  - WIDTH = 16 and AMT_W = 4 defaults.
- One sub-module: the existing combinational `shifter` (16-bit, 1-position left/right), instantiated once, with the working register as its input.
- Sign-fill override, bits_lost logic, the counter and the FSM stay in shift_sequencer.

Test Plan:
1. operand 0x0001, amount 4, dir left -> result 0x0010, result_valid 5 cycles after accept, bits_lost 0, busy high throughout.
2. operand 0x8000, amount 3, dir right: arith=1 -> 0xF000; arith=0 -> 0x1000; bits_lost 0 in both.
3. operand 0x1234, amount 0 -> result 0x1234 valid 1 cycle after accept; start_ready low until the cycle after result_ready.
4. operand 0xC001, amount 1, left -> 0x8002, bits_lost 1. Then operand 0x0003, amount 2, right logical -> 0x0000, bits_lost 1.
5. Back-pressure: result_ready held low 3 cycles in DONE -> result/result_valid stable. A start_valid pulse during DONE is not accepted (start_ready 0).
6. Two interruption cases:
   - abort on the 2nd SHIFT cycle of amount 8 -> IDLE next cycle, no result_valid, bits_lost 0.
   - rst_n low mid-SHIFT -> all outputs reset immediately; the next request then completes normally.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer.
// Holds the state encoding, direction codes and default widths.
package shift_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned AMT_W = 4;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Existing 16-bit single-position combinational shifter.
// Zero-fills the vacated bit in both directions; sign fill is applied by the caller.
module shifter
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0] data,
    input  logic             dir,
    output logic [WIDTH-1:0] shifted
);

    always_comb begin
        shifted = '0;
        if (dir == DIR_LEFT) begin
            shifted = {data[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {1'b0, data[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: steps the 1-bit shifter once per clock until the
// requested amount is reached, then returns the result over a valid/ready handshake.
module shift_sequencer #(
    parameter int unsigned WIDTH = shift_pkg::WIDTH,
    parameter int unsigned AMT_W = shift_pkg::AMT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amount,
    input  logic             dir,
    input  logic             arith,
    input  logic             abort,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             bits_lost,
    output logic             busy
);

    import shift_pkg::*;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [AMT_W-1:0] count;
    logic             dir_q;
    logic             arith_q;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] next_work;
    logic             lost_bit;

    shifter u_shifter (
        .data    (work),
        .dir     (dir_q),
        .shifted (shifted)
    );

    // Arithmetic right shifts keep the sign bit in place instead of zero-filling it.
    always_comb begin
        next_work = shifted;
        if (dir_q == DIR_RIGHT && arith_q) begin
            next_work[WIDTH-1] = work[WIDTH-1];
        end
        lost_bit = (dir_q == DIR_LEFT) ? work[WIDTH-1] : work[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            work         <= '0;
            count        <= '0;
            dir_q        <= DIR_LEFT;
            arith_q      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            bits_lost    <= 1'b0;
            busy         <= 1'b0;
            start_ready  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        work        <= operand;
                        dir_q       <= dir;
                        arith_q     <= arith;
                        count       <= amount;
                        bits_lost   <= 1'b0;
                        busy        <= 1'b1;
                        start_ready <= 1'b0;
                        if (amount == '0) begin
                            state        <= ST_DONE;
                            result       <= operand;
                            result_valid <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    // Abort wins over completion; the previous result stays visible.
                    if (abort) begin
                        state       <= ST_IDLE;
                        bits_lost   <= 1'b0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                    end else begin
                        work      <= next_work;
                        bits_lost <= bits_lost | lost_bit;
                        count     <= count - AMT_W'(1);
                        if (count == AMT_W'(1)) begin
                            state        <= ST_DONE;
                            result       <= next_work;
                            result_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        state        <= ST_IDLE;
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        start_ready  <= 1'b1;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    start_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer with hand-computed expectations.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [15:0] operand = '0;
    logic [3:0]  amount = '0;
    logic        dir = 1'b0;
    logic        arith = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] result;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic        bits_lost;
    logic        busy;

    int unsigned checks = 0;
    int unsigned fails = 0;
    int unsigned lat;
    logic        busy_ok;

    shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .operand      (operand),
        .amount       (amount),
        .dir          (dir),
        .arith        (arith),
        .abort        (abort),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .bits_lost    (bits_lost),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accepts one request, then counts cycles until result_valid (bounded).
    task automatic launch(input logic [15:0] op, input logic [3:0] amt, input logic d,
                          input logic a, output int unsigned cycles, output logic busy_seen);
        int unsigned n;
        operand     = op;
        amount      = amt;
        dir         = d;
        arith       = a;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        operand     = 16'hDEAD;
        amount      = 4'hF;
        n           = 1;
        busy_seen   = 1'b1;
        while (!result_valid && n < 40) begin
            if (!busy) busy_seen = 1'b0;
            step();
            n++;
        end
        if (!busy) busy_seen = 1'b0;
        cycles = result_valid ? n : 0;
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [15:0] op, input logic [3:0] amt,
                          input logic d, input logic a, input logic [15:0] exp_res,
                          input logic exp_lost);
        int unsigned c;
        logic        b;
        launch(op, amt, d, a, c, b);
        check({tag, " latency"}, c, 32'(amt) + 1);
        check({tag, " result"}, result, exp_res);
        check({tag, " bits_lost"}, bits_lost, exp_lost);
        check({tag, " busy"}, b, 1'b1);
        check({tag, " start_ready in DONE"}, start_ready, 1'b0);
        handshake();
        check({tag, " valid drop"}, result_valid, 1'b0);
        check({tag, " ready after"}, start_ready, 1'b1);
        check({tag, " result held"}, result, exp_res);
    endtask

    initial begin
        #12;
        check("reset result", result, 16'h0000);
        check("reset valid", result_valid, 1'b0);
        check("reset bits_lost", bits_lost, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset start_ready", start_ready, 1'b1);
        rst_n = 1'b1;
        step();

        run_op("left4", 16'h0001, 4'd4, 1'b0, 1'b0, 16'h0010, 1'b0);
        run_op("ras3", 16'h8000, 4'd3, 1'b1, 1'b1, 16'hF000, 1'b0);
        run_op("rls3", 16'h8000, 4'd3, 1'b1, 1'b0, 16'h1000, 1'b0);
        run_op("amt0", 16'h1234, 4'd0, 1'b0, 1'b0, 16'h1234, 1'b0);
        run_op("left1 lost", 16'hC001, 4'd1, 1'b0, 1'b0, 16'h8002, 1'b1);
        run_op("rls2 lost", 16'h0003, 4'd2, 1'b1, 1'b0, 16'h0000, 1'b1);
        run_op("left arith", 16'h4001, 4'd1, 1'b0, 1'b1, 16'h8002, 1'b0);
        run_op("left15", 16'hA5A5, 4'd15, 1'b0, 1'b0, 16'h8000, 1'b1);
        run_op("ras15", 16'h8001, 4'd15, 1'b1, 1'b1, 16'hFFFF, 1'b1);

        // Back-pressure in DONE with an ignored start_valid pulse.
        launch(16'h00F0, 4'd4, 1'b1, 1'b0, lat, busy_ok);
        check("bp latency", lat, 32'd5);
        for (int i = 0; i < 3; i++) begin
            operand     = 16'h5555;
            amount      = 4'd0;
            start_valid = (i == 1);
            check("bp start_ready", start_ready, 1'b0);
            step();
            check("bp valid", result_valid, 1'b1);
            check("bp result", result, 16'h000F);
        end
        start_valid = 1'b0;
        check("bp bits_lost", bits_lost, 1'b0);
        handshake();
        check("bp valid drop", result_valid, 1'b0);
        check("bp result kept", result, 16'h000F);

        // Abort on the second SHIFT cycle.
        operand = 16'hFFFF; amount = 4'd8; dir = 1'b0; arith = 1'b0;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        check("abort busy", busy, 1'b1);
        step();
        check("abort lost before", bits_lost, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort idle ready", start_ready, 1'b1);
        check("abort busy low", busy, 1'b0);
        check("abort bits_lost", bits_lost, 1'b0);
        check("abort result", result, 16'h000F);
        for (int i = 0; i < 10; i++) begin
            step();
            check("abort no valid", result_valid, 1'b0);
        end

        // Asynchronous reset mid-SHIFT, then a normal operation.
        operand = 16'hFFFF; amount = 4'd5; dir = 1'b1; arith = 1'b1;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst result", result, 16'h0000);
        check("arst valid", result_valid, 1'b0);
        check("arst busy", busy, 1'b0);
        check("arst bits_lost", bits_lost, 1'b0);
        check("arst start_ready", start_ready, 1'b1);
        step();
        rst_n = 1'b1;
        step();
        run_op("post reset", 16'h0F0F, 4'd2, 1'b0, 1'b0, 16'h3C3C, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
